// File: rtl/hpm_sample_ctrl.sv
// Arbiter for the perf_counters port: CSR accesses take strict priority, and a periodic
// sampler scans the MHPM counters into a first-word-fall-through FIFO of {idx, value} records.
module hpm_sample_ctrl #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned PeriodWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   csr_req_i,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [XLEN-1:0]        csr_wdata_i,
  output logic                   csr_gnt_o,
  output logic                   csr_rvalid_o,
  output logic [XLEN-1:0]        csr_rdata_o,
  output logic [11:0]            perf_addr_o,
  output logic                   perf_we_o,
  output logic [XLEN-1:0]        perf_wdata_o,
  input  logic [XLEN-1:0]        perf_rdata_i,
  input  logic                   sample_en_i,
  input  logic [PeriodWidth-1:0] sample_period_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [4:0]             sample_idx_o,
  output logic [63:0]            sample_data_o,
  output logic                   scan_busy_o
);

  localparam int unsigned PtrW    = $clog2(FifoDepth);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned SampleW = 5 + 64;
  localparam bit          TwoReads = (XLEN == 32);
  localparam logic [11:0] AddrLo  = 12'hB03;
  localparam logic [11:0] AddrHi  = 12'hB83;
  localparam logic [4:0]  LastIdx = 5'(NumCounters - 1);

  typedef enum logic [1:0] {StIdle, StWait, StScan} state_e;

  state_e                 state_q, state_d;
  logic [PeriodWidth-1:0] timer_q, timer_d;
  logic [4:0]             idx_q, idx_d;
  logic                   hi_q, hi_d;

  logic [SampleW-1:0]     fifo_mem [FifoDepth];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   fifo_full, fifo_empty;
  logic                   smp_own, last_read, push, pop;
  logic [63:0]            smp_value;

  assign fifo_full  = (count_q == CntW'(FifoDepth));
  assign fifo_empty = (count_q == '0);
  assign smp_own    = !csr_req_i && (state_q == StScan) && !fifo_full;
  assign last_read  = !TwoReads || hi_q;
  assign push       = smp_own && last_read;
  assign pop        = !fifo_empty && sample_ready_i;

  // Port mux: CSR first, then the sampler (read-only), else idle zeros
  always_comb begin
    csr_gnt_o    = csr_req_i;
    perf_addr_o  = '0;
    perf_we_o    = 1'b0;
    perf_wdata_o = '0;
    if (csr_req_i) begin
      perf_addr_o  = csr_addr_i;
      perf_we_o    = csr_we_i;
      perf_wdata_o = csr_wdata_i;
    end else if (smp_own) begin
      perf_addr_o  = (hi_q ? AddrHi : AddrLo) + 12'(idx_q);
    end
  end

  // CSR read return, one cycle after grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csr_rvalid_o <= 1'b0;
      csr_rdata_o  <= '0;
    end else begin
      csr_rvalid_o <= csr_req_i && !csr_we_i;
      if (csr_req_i && !csr_we_i) csr_rdata_o <= perf_rdata_i;
    end
  end

  // Narrow ports assemble the record from a held low half plus the live high half
  if (TwoReads) begin : g_x32
    logic [31:0] lo_q;
    always_ff @(posedge clk_i) begin
      if (smp_own && !hi_q) lo_q <= perf_rdata_i;
    end
    assign smp_value = {perf_rdata_i, lo_q};
  end else begin : g_x64
    assign smp_value = perf_rdata_i;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    unique case (state_q)
      StIdle: begin
        if (sample_en_i) begin
          state_d = StWait;
          timer_d = sample_period_i;
        end
      end
      StWait: begin
        if (!sample_en_i) begin
          state_d = StIdle;
        end else if (timer_q == '0) begin
          state_d = StScan;
          idx_d   = '0;
          hi_d    = 1'b0;
        end else begin
          timer_d = timer_q - PeriodWidth'(1);
        end
      end
      StScan: begin
        // A scan always runs to completion; enable is only consulted at its end
        if (smp_own) begin
          if (!last_read) begin
            hi_d = 1'b1;
          end else begin
            hi_d = 1'b0;
            if (idx_q == LastIdx) begin
              idx_d = '0;
              if (sample_en_i) begin
                state_d = StWait;
                timer_d = sample_period_i;
              end else begin
                state_d = StIdle;
              end
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
    end
  end

  // Sample FIFO; push already excludes a full FIFO, so a same-cycle pop never makes room
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {idx_q, smp_value};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign sample_valid_o                = !fifo_empty;
  assign {sample_idx_o, sample_data_o} = fifo_mem[rd_ptr_q];
  assign scan_busy_o                   = (state_q == StScan);

endmodule

// File: doc/hpm_sample_ctrl.md
Name: hpm_sample_ctrl

Overview:
Controller and arbiter in front of the perf_counters SRAM-like port (addr/we/data_i/data_o). It shares that port between the CSR file, which has strict priority, and a periodic sampling engine. Each sampling period, the engine scans all MHPM counters (mhpmcounter3 upward) and pushes {index, 64-bit value} records into a small FIFO for the trace sink.

Parameters:
NumCounters, 6, number of generic counters scanned (equals MHPMCounterNum)
XLEN, 64, perf port data width (32 or 64)
FifoDepth, 4, sample FIFO entries (power of two, >=2)
PeriodWidth, 32, width of the sample period register

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
csr_req_i  in  1  CSR file access request
csr_we_i  in  1  CSR write (1) or read (0)
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  CSR write data
csr_gnt_o  out  1  request granted this cycle
csr_rvalid_o  out  1  read data valid (one cycle after grant)
csr_rdata_o  out  XLEN  registered read data
perf_addr_o  out  12  to perf_counters addr_i
perf_we_o  out  1  to perf_counters we_i
perf_wdata_o  out  XLEN  to perf_counters data_i
perf_rdata_i  in  XLEN  from perf_counters data_o (combinational on addr)
sample_en_i  in  1  sampling enable
sample_period_i  in  PeriodWidth  idle cycles between scans
sample_valid_o  out  1  FIFO head valid
sample_ready_i  in  1  sink accepts head
sample_idx_o  out  5  counter index, 0 means mhpmcounter3
sample_data_o  out  64  counter value
scan_busy_o  out  1  FSM is in SCAN

Behaviour:
- Reset values: csr_gnt_o=0, csr_rvalid_o=0, csr_rdata_o=0, perf_* =0, sample_valid_o=0, scan_busy_o=0. FIFO is empty and FSM is in IDLE.
- Reset mid-scan aborts the scan and discards all FIFO contents.
- Arbitration, per cycle:
  - If csr_req_i=1: csr_gnt_o=1 in the same cycle. perf_addr_o/we/wdata are driven combinationally from the csr_* inputs.
  - On a CSR read, perf_rdata_i is captured into csr_rdata_o and csr_rvalid_o=1 on the next cycle.
  - A CSR write produces no rvalid.
  - If no CSR request and the FSM is in SCAN with FIFO not full: the sampler owns the port, with perf_we_o=0.
  - Otherwise the port is idle: addr=0, we=0, wdata=0.
  - The sampler never asserts perf_we_o, so it does not inhibit counting.
- FSM states IDLE, WAIT, SCAN:
  - IDLE -> WAIT when sample_en_i=1. The timer loads sample_period_i on entry to WAIT.
  - WAIT: the timer decrements each cycle and moves to SCAN the cycle after it reads 0. Period 0 therefore enters SCAN one cycle after entering WAIT.
  - WAIT -> IDLE immediately if sample_en_i=0.
  - SCAN: index i runs 0..NumCounters-1.
    - XLEN=64: one read per counter at 0xB03+i.
    - XLEN=32: two reads per counter, low half at 0xB03+i first, then high half at 0xB83+i. The halves may be non-atomic; this is accepted.
    - A sampler read happens only in a cycle the sampler owns the port. A record is pushed in the cycle its last read completes.
    - The index advances only on a completed read; it stalls while the CSR holds the port or the FIFO is full.
    - After pushing index NumCounters-1: go to WAIT (timer reloaded) if sample_en_i=1, else IDLE.
    - Deasserting sample_en_i mid-scan does not abort; the scan completes.
  - The timer does not run in IDLE or SCAN. scan_busy_o=1 exactly in SCAN.
- Starvation: continuous csr_req_i stalls the scan indefinitely. No samples are dropped; the scan resumes where it stalled.
- FIFO:
  - First-word-fall-through; pop when sample_valid_o && sample_ready_i.
  - Push is gated on not-full as registered at cycle start. A pop in the same cycle does not free space for a push.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - Pointers wrap modulo FifoDepth. Records are never overwritten or dropped.
- sample_period_i is sampled only on timer load; changes during WAIT take effect at the next load.

Test Plan:
- Reset with sample_en_i=0; CSR read 0xB03 with perf_rdata_i=64'h1234 -> csr_gnt_o=1 in the same cycle, csr_rvalid_o=1 and csr_rdata_o=64'h1234 the next cycle, FSM stays in IDLE.
- XLEN=64, sample_period_i=3, sink always ready -> 4 WAIT cycles, then 6 consecutive reads at 0xB03..0xB08 and 6 records idx 0..5. scan_busy_o is high for 6 cycles, then the FSM returns to WAIT.
- In SCAN at idx 2, hold csr_req_i for 3 cycles -> perf_addr_o follows csr_addr_i for those 3 cycles. idx 2 is read afterwards; there is no gap or duplicate in the idx sequence.
- sample_ready_i=0 for a whole scan with FifoDepth=4 -> exactly 4 records held and the scan stalls at idx 4. Raising ready delivers idx 0..5 in order with no loss.
- XLEN=32 with a counter model returning low=32'hAAAA_0001, high=32'h0000_0002 -> reads alternate 0xB03+i and 0xB83+i, sample_data_o=64'h0000_0002_AAAA_0001.
- Drop sample_en_i mid-scan at idx 3 -> idx 3..5 are still pushed, then IDLE. Assert rst_i mid-scan -> next cycle the FIFO is empty, sample_valid_o=0 and perf_addr_o=0.
